// File: rtl/alu_ctl_idex.sv
// alu_ctl_idex: ID/EX pipeline stage feeding the main ALU.
//
// Decodes the RV32I/RV64I opcode and funct fields into an ALU operation code
// and a shift select. It picks operands A and B and registers everything for
// the EX stage. It also registers the branch-resolution hints that are used
// with the ALU zero/less result.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_valid                ID holds a real instruction this cycle
//   i_stall, i_flush       hold the EX registers / replace them with a bubble
//   i_opcode, i_funct3,
//   i_funct7_5             instruction fields [6:0], [14:12], [30]
//   i_pc, i_rs1_data,
//   i_rs2_data, i_imm      W-bit operand sources
//   o_valid                EX holds a real instruction
//   o_op_a, o_op_b         ALU operands
//   o_alu_op, o_alu_shift  ALU control and shift-select codes
//   o_is_branch,
//   o_br_use_zero,
//   o_br_invert            branch-resolution hints
//   o_illegal              unsupported opcode/funct combination
module alu_ctl_idex #(
  parameter  int XLEN = 2,                 // width code: 1 = 32 bit, 2 = 64 bit
  localparam int W    = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_funct3,
  input  logic         i_funct7_5,
  input  logic [W-1:0] i_pc,
  input  logic [W-1:0] i_rs1_data,
  input  logic [W-1:0] i_rs2_data,
  input  logic [W-1:0] i_imm,
  output logic         o_valid,
  output logic [W-1:0] o_op_a,
  output logic [W-1:0] o_op_b,
  output logic [2:0]   o_alu_op,
  output logic [1:0]   o_alu_shift,
  output logic         o_is_branch,
  output logic         o_br_use_zero,
  output logic         o_br_invert,
  output logic         o_illegal
);

  localparam logic [2:0] ALU_CTL_ADD      = 3'd0;
  localparam logic [2:0] ALU_CTL_SUB      = 3'd1;
  localparam logic [2:0] ALU_CTL_LESS_SIG = 3'd2;
  localparam logic [2:0] ALU_CTL_LESS_UNS = 3'd3;
  localparam logic [2:0] ALU_CTL_XOR      = 3'd4;
  localparam logic [2:0] ALU_CTL_OR       = 3'd5;
  localparam logic [2:0] ALU_CTL_AND      = 3'd6;
  localparam logic [2:0] ALU_CTL_SHIFT    = 3'd7;

  localparam logic [1:0] ALU_SHIFT_SLL = 2'd0;
  localparam logic [1:0] ALU_SHIFT_SRL = 2'd1;
  localparam logic [1:0] ALU_SHIFT_SRA = 2'd2;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [2:0]   alu_op;
    logic [1:0]   alu_shift;
    logic         is_branch;
    logic         br_use_zero;
    logic         br_invert;
    logic         illegal;
  } ex_t;

  function automatic ex_t bubble_f();
    ex_t b;
    b.valid       = 1'b0;
    b.op_a        = '0;
    b.op_b        = '0;
    b.alu_op      = ALU_CTL_ADD;
    b.alu_shift   = ALU_SHIFT_SLL;
    b.is_branch   = 1'b0;
    b.br_use_zero = 1'b0;
    b.br_invert   = 1'b0;
    b.illegal     = 1'b0;
    return b;
  endfunction

  ex_t dec;
  ex_t ex_d;
  ex_t ex_q;

  // ID: combinational decode of the current instruction
  always_comb begin
    dec       = bubble_f();
    dec.valid = 1'b1;
    unique case (i_opcode)
      OPC_OP, OPC_OPIMM: begin
        dec.op_a = i_rs1_data;
        dec.op_b = (i_opcode == OPC_OP) ? i_rs2_data : i_imm;
        unique case (i_funct3)
          // funct7_5 selects SUB only for register-register; ADDI has no SUBI.
          3'b000: dec.alu_op = (i_opcode == OPC_OP && i_funct7_5) ? ALU_CTL_SUB : ALU_CTL_ADD;
          3'b001: begin
            dec.alu_op  = ALU_CTL_SHIFT;
            dec.illegal = (i_opcode == OPC_OPIMM) && i_funct7_5;
          end
          3'b010: dec.alu_op = ALU_CTL_LESS_SIG;
          3'b011: dec.alu_op = ALU_CTL_LESS_UNS;
          3'b100: dec.alu_op = ALU_CTL_XOR;
          3'b101: begin
            dec.alu_op    = ALU_CTL_SHIFT;
            dec.alu_shift = i_funct7_5 ? ALU_SHIFT_SRA : ALU_SHIFT_SRL;
          end
          3'b110: dec.alu_op = ALU_CTL_OR;
          default: dec.alu_op = ALU_CTL_AND;
        endcase
      end
      OPC_LUI: dec.op_b = i_imm;
      OPC_AUIPC: begin
        dec.op_a = i_pc;
        dec.op_b = i_imm;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.op_a = i_rs1_data;
        dec.op_b = i_imm;
      end
      OPC_BRANCH: begin
        dec.op_a      = i_rs1_data;
        dec.op_b      = i_rs2_data;
        dec.is_branch = 1'b1;
        dec.br_invert = i_funct3[0];
        unique case (i_funct3[2:1])
          2'b00: begin
            dec.alu_op      = ALU_CTL_SUB;
            dec.br_use_zero = 1'b1;
          end
          2'b10: dec.alu_op = ALU_CTL_LESS_SIG;
          2'b11: dec.alu_op = ALU_CTL_LESS_UNS;
          default: begin
            dec.illegal   = 1'b1;
            dec.br_invert = 1'b0;
          end
        endcase
      end
      // Link value pc + 4 is computed by the ALU itself.
      OPC_JAL, OPC_JALR: begin
        dec.op_a = i_pc;
        dec.op_b = W'(4);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Update priority: flush, then stall, then load decode or bubble.
  always_comb begin
    ex_d = ex_q;
    if (i_flush)       ex_d = bubble_f();
    else if (i_stall)  ex_d = ex_q;
    else if (i_valid)  ex_d = dec;
    else               ex_d = bubble_f();
  end

  // ID/EX boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ex_q <= bubble_f();
    else       ex_q <= ex_d;
  end

  assign o_valid       = ex_q.valid;
  assign o_op_a        = ex_q.op_a;
  assign o_op_b        = ex_q.op_b;
  assign o_alu_op      = ex_q.alu_op;
  assign o_alu_shift   = ex_q.alu_shift;
  assign o_is_branch   = ex_q.is_branch;
  assign o_br_use_zero = ex_q.br_use_zero;
  assign o_br_invert   = ex_q.br_invert;
  assign o_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_alu_ctl_idex.sv
module tb_alu_ctl_idex;

  localparam int XLEN = 2;
  localparam int W    = 1 << (XLEN + 4);

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, LSIG = 3'd2, LUNS = 3'd3,
                         XOR_ = 3'd4, OR_ = 3'd5, AND_ = 3'd6, SHIFT = 3'd7;
  localparam logic [1:0] SLL = 2'd0, SRL = 2'd1, SRA = 2'd2;

  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111,
                         AUIPC = 7'b0010111, LOAD = 7'b0000011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [1:0]   sh;
    logic         br;
    logic         uz;
    logic         inv;
    logic         ill;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [6:0]   i_opcode = '0;
  logic [2:0]   i_funct3 = '0;
  logic         i_funct7_5 = 1'b0;
  logic [W-1:0] i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0;
  logic         o_valid;
  logic [W-1:0] o_op_a, o_op_b;
  logic [2:0]   o_alu_op;
  logic [1:0]   o_alu_shift;
  logic         o_is_branch, o_br_use_zero, o_br_invert, o_illegal;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q;
  exp_t got;

  alu_ctl_idex #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_stall(i_stall),
    .i_flush(i_flush), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7_5(i_funct7_5), .i_pc(i_pc), .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data), .i_imm(i_imm), .o_valid(o_valid),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_alu_op(o_alu_op),
    .o_alu_shift(o_alu_shift), .o_is_branch(o_is_branch),
    .o_br_use_zero(o_br_use_zero), .o_br_invert(o_br_invert),
    .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic exp_t bubble();
    exp_t e;
    e = '0;
    e.op = ADD;
    e.sh = SLL;
    return e;
  endfunction

  // Table-driven decode taken straight from the instruction-set rules.
  function automatic exp_t decode(logic [6:0] opc, logic [2:0] f3, logic f7,
                                  logic [W-1:0] pc, logic [W-1:0] rs1,
                                  logic [W-1:0] rs2, logic [W-1:0] imm);
    logic [2:0] alu_tbl [8];
    logic [2:0] br_tbl  [4];
    exp_t e;
    alu_tbl = '{ADD, SHIFT, LSIG, LUNS, XOR_, SHIFT, OR_, AND_};
    br_tbl  = '{SUB, ADD, LSIG, LUNS};
    e   = bubble();
    e.v = 1'b1;
    if (opc == OP || opc == OPIMM) begin
      e.a  = rs1;
      e.b  = (opc == OP) ? rs2 : imm;
      e.op = alu_tbl[f3];
      if (f3 == 3'd0 && opc == OP && f7) e.op = SUB;
      if (f3 == 3'd5) e.sh = f7 ? SRA : SRL;
      if (f3 == 3'd1 && opc == OPIMM && f7) e.ill = 1'b1;
    end else if (opc == LUI) begin
      e.b = imm;
    end else if (opc == AUIPC) begin
      e.a = pc; e.b = imm;
    end else if (opc == LOAD || opc == STORE) begin
      e.a = rs1; e.b = imm;
    end else if (opc == BRANCH) begin
      e.a  = rs1; e.b = rs2; e.br = 1'b1;
      e.op = br_tbl[f3[2:1]];
      if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
      else begin
        e.uz  = (f3 < 3'd2);
        e.inv = f3[0];
      end
    end else if (opc == JAL || opc == JALR) begin
      e.a = pc; e.b = 4;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.v = o_valid; o.a = o_op_a; o.b = o_op_b; o.op = o_alu_op; o.sh = o_alu_shift;
    o.br = o_is_branch; o.uz = o_br_use_zero; o.inv = o_br_invert; o.ill = o_illegal;
    return o;
  endfunction

  // Apply one cycle of stimulus and advance the model by the same edge.
  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [W-1:0] pc, input logic [W-1:0] rs1,
                       input logic [W-1:0] rs2, input logic [W-1:0] imm);
    i_valid = v; i_stall = st; i_flush = fl; i_opcode = opc; i_funct3 = f3;
    i_funct7_5 = f7; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm;
    if (fl)      exp_q = bubble();
    else if (st) exp_q = exp_q;
    else if (v)  exp_q = decode(opc, f3, f7, pc, rs1, rs2, imm);
    else         exp_q = bubble();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q = bubble();
    got = observe(); vectors++;
    if (got !== bubble()) begin
      miscompares++; $display("FAIL reset_state got=%h want=%h", got, bubble());
    end
    drive(1, 0, 0, OP, 3'd0, 0, 0, 64'd1, 64'd2, 0);
    vectors++;
    if (o_valid !== 1'b1) begin
      miscompares++; $display("FAIL reset_first_valid got=%b want=1", o_valid);
    end
    // Asynchronous assertion mid-cycle, no clock edge in between.
    #2 i_rst = 1'b1;
    #1;
    got = observe(); vectors++;
    if (got !== bubble()) begin
      miscompares++; $display("FAIL reset_async got=%h want=%h", got, bubble());
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_q = bubble();
    drive(1, 0, 0, OP, 3'd0, 0, 0, 64'd5, 64'd6, 0);
    vectors++;
    if (o_valid !== 1'b1 || o_alu_op !== ADD) begin
      miscompares++; $display("FAIL reset_release got=%b/%0d want=1/%0d", o_valid, o_alu_op, ADD);
    end
  endtask

  task automatic test_op_decode();
    drive(1, 0, 0, OP, 3'd0, 1, 0, 64'd7, 64'd3, 0);
    vectors++;
    if (o_alu_op !== SUB || o_op_a !== 64'd7 || o_op_b !== 64'd3) begin
      miscompares++; $display("FAIL op_sub got=%0d/%0d/%0d want=%0d/7/3", o_alu_op, o_op_a, o_op_b, SUB);
    end
    drive(1, 0, 0, OP, 3'd5, 1, 0, 64'd7, 64'd3, 0);
    vectors++;
    if (o_alu_op !== SHIFT || o_alu_shift !== SRA) begin
      miscompares++; $display("FAIL op_sra got=%0d/%0d want=%0d/%0d", o_alu_op, o_alu_shift, SHIFT, SRA);
    end
    drive(1, 0, 0, OP, 3'd5, 0, 0, 64'd7, 64'd3, 0);
    vectors++;
    if (o_alu_op !== SHIFT || o_alu_shift !== SRL) begin
      miscompares++; $display("FAIL op_srl got=%0d/%0d want=%0d/%0d", o_alu_op, o_alu_shift, SHIFT, SRL);
    end
    drive(1, 0, 0, OP, 3'd3, 0, 0, 64'd7, 64'd3, 0);
    vectors++;
    if (o_alu_op !== LUNS || o_illegal !== 1'b0) begin
      miscompares++; $display("FAIL op_sltu got=%0d/%b want=%0d/0", o_alu_op, o_illegal, LUNS);
    end
  endtask

  task automatic test_imm_pc();
    logic [W-1:0] m5;
    m5 = '1;
    m5 = m5 - 4;
    drive(1, 0, 0, OPIMM, 3'd0, 1, 0, 64'd7, 64'd3, -64'sd5);
    vectors++;
    if (o_alu_op !== ADD || o_op_b !== m5) begin
      miscompares++; $display("FAIL addi_f7 got=%0d/%h want=%0d/%h", o_alu_op, o_op_b, ADD, m5);
    end
    drive(1, 0, 0, AUIPC, 3'd0, 0, 64'h100, 64'd9, 64'd9, 64'h1000);
    vectors++;
    if (o_op_a !== 64'h100 || o_op_b !== 64'h1000 || o_alu_op !== ADD) begin
      miscompares++; $display("FAIL auipc got=%h/%h/%0d want=100/1000/%0d", o_op_a, o_op_b, o_alu_op, ADD);
    end
    drive(1, 0, 0, JAL, 3'd0, 0, 64'h40, 64'd9, 64'd9, 64'h77);
    vectors++;
    if (o_op_a !== 64'h40 || o_op_b !== 64'd4 || o_alu_op !== ADD) begin
      miscompares++; $display("FAIL jal got=%h/%h/%0d want=40/4/%0d", o_op_a, o_op_b, o_alu_op, ADD);
    end
    drive(1, 0, 0, OPIMM, 3'd1, 1, 0, 64'd1, 64'd2, 64'd3);
    vectors++;
    if (o_illegal !== 1'b1 || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL slli_f7 got=%b/%b want=1/1", o_illegal, o_valid);
    end
  endtask

  task automatic test_branch();
    drive(1, 0, 0, BRANCH, 3'd1, 0, 0, 64'd4, 64'd5, 0);
    vectors++;
    if ({o_alu_op, o_is_branch, o_br_use_zero, o_br_invert} !== {SUB, 3'b111}) begin
      miscompares++; $display("FAIL bne got=%0d/%b%b%b want=%0d/111", o_alu_op, o_is_branch, o_br_use_zero, o_br_invert, SUB);
    end
    drive(1, 0, 0, BRANCH, 3'd7, 0, 0, 64'd4, 64'd5, 0);
    vectors++;
    if ({o_alu_op, o_is_branch, o_br_use_zero, o_br_invert} !== {LUNS, 3'b101}) begin
      miscompares++; $display("FAIL bgeu got=%0d/%b%b%b want=%0d/101", o_alu_op, o_is_branch, o_br_use_zero, o_br_invert, LUNS);
    end
    drive(1, 0, 0, BRANCH, 3'd2, 0, 0, 64'd4, 64'd5, 0);
    vectors++;
    if (o_illegal !== 1'b1 || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL br_f3_010 got=%b/%b want=1/1", o_illegal, o_valid);
    end
  endtask

  task automatic test_hold_bubble();
    exp_t held;
    drive(1, 0, 0, OP, 3'd0, 0, 0, 64'd11, 64'd22, 0);
    held = observe();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, OP, 3'($urandom), 1'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      got = observe(); vectors++;
      if (got !== held || got !== exp_q) begin
        miscompares++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, got, held);
      end
    end
    drive(1, 1, 1, OP, 3'd0, 0, 0, 64'd1, 64'd1, 0);
    got = observe(); vectors++;
    if (got !== bubble()) begin
      miscompares++; $display("FAIL stall_flush got=%h want=%h", got, bubble());
    end
    drive(1, 0, 0, LOAD, 3'd2, 0, 0, 64'd8, 64'd0, 64'd16);
    drive(0, 0, 0, LOAD, 3'd2, 0, 0, 64'd8, 64'd0, 64'd16);
    got = observe(); vectors++;
    if (got !== bubble()) begin
      miscompares++; $display("FAIL invalid_bubble got=%h want=%h", got, bubble());
    end
  endtask

  task automatic test_illegal();
    drive(1, 0, 0, 7'h7F, 3'd0, 0, 64'h55, 64'h66, 64'h77, 64'h88);
    vectors++;
    if (o_illegal !== 1'b1 || o_op_a !== '0 || o_op_b !== '0 || o_alu_op !== ADD || o_valid !== 1'b1) begin
      miscompares++; $display("FAIL illegal_opc got=%b/%h/%h/%0d want=1/0/0/%0d", o_illegal, o_op_a, o_op_b, o_alu_op, ADD);
    end
    drive(1, 0, 1, 7'h7F, 3'd0, 0, 0, 0, 0, 0);
    vectors++;
    if (o_illegal !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++; $display("FAIL illegal_flush got=%b/%b want=0/0", o_illegal, o_valid);
    end
  endtask

  task automatic test_random();
    logic [6:0] opcs [10];
    logic [6:0] opc;
    opcs = '{OP, OPIMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, 7'h00};
    for (int i = 0; i < 400; i++) begin
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 8)];
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), opc, 3'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom});
      got = observe(); vectors++;
      if (got !== exp_q) begin
        miscompares++; $display("FAIL random[%0d] got=%h want=%h", i, got, exp_q);
      end
    end
  endtask

  initial begin
    exp_q = bubble();
    test_reset();
    test_op_decode();
    test_imm_pc();
    test_branch();
    test_hold_bubble();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctl_idex.md
Name: alu_ctl_idex

Overview:
ID/EX pipeline stage that produces everything the main ALU consumes: decodes RV32I/RV64I opcode/funct fields into ALU op and shift select, selects operands A/B, and registers them for the EX stage. It is the upstream (driving) end of the ALU control/operand interface. It supports stall (hold) and flush (bubble), and emits branch-resolution hints for use with the ALU zero/less result.

Parameters:
XLEN, `XLEN_64b, width code from Constants.vh; datapath width W = 1<<(XLEN+4).

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_valid  in  1  ID holds a real instruction this cycle.
i_stall  in  1  hold all EX-side registers.
i_flush  in  1  replace the EX-side contents with a bubble.
i_opcode  in  7  instruction [6:0].
i_funct3  in  3  instruction [14:12].
i_funct7_5  in  1  instruction [30].
i_pc  in  W  PC of the instruction.
i_rs1_data  in  W  register-file read data for rs1.
i_rs2_data  in  W  register-file read data for rs2.
i_imm  in  W  sign-extended immediate from the immediate generator.
o_valid  out  1  EX stage holds a real instruction.
o_op_a  out  W  ALU operand A.
o_op_b  out  W  ALU operand B.
o_alu_op  out  3  `ALU_CTL_* code.
o_alu_shift  out  2  `ALU_SHIFT_* code.
o_is_branch  out  1  conditional branch in EX.
o_br_use_zero  out  1  branch decision uses the ALU zero flag (BEQ/BNE); 0 means it uses alu_out[0].
o_br_invert  out  1  invert the raw condition (BNE/BGE/BGEU).
o_illegal  out  1  opcode or funct combination is unsupported.

Behaviour:
- Decode is combinational on the ID inputs. All outputs are registered, so latency is exactly 1 clock.
- Default shift select: o_alu_shift = `ALU_SHIFT_SLL unless noted.
- OP (0110011), B = rs2, A = rs1. funct3 decodes as:
  - 000: SUB if funct7_5 = 1, else ADD.
  - 001: SHIFT, SLL.
  - 010: LESS_SIG.
  - 011: LESS_UNS.
  - 100: XOR.
  - 101: SHIFT; SRA if funct7_5 = 1, else SRL.
  - 110: OR.
  - 111: AND.
- OP-IMM (0010011): same as OP except B = imm and funct3 000 is always ADD. SLLI with funct7_5 = 1 is illegal.
- LUI (0110111): A = 0, B = imm, ADD.
- AUIPC (0010111): A = pc, B = imm, ADD.
- LOAD (0000011) and STORE (0100011): A = rs1, B = imm, ADD.
- BRANCH (1100011): A = rs1, B = rs2, o_is_branch = 1.
  - 000/001: SUB, use_zero = 1, invert = funct3[0].
  - 100/101: LESS_SIG, use_zero = 0, invert = funct3[0].
  - 110/111: LESS_UNS, use_zero = 0, invert = funct3[0].
  - 010/011: illegal.
- JAL (1101111) and JALR (1100111): A = pc, B = 4, ADD (link value).
- Any other opcode: illegal; A = B = 0, ADD.
- Bubble value: o_valid = 0, all data outputs 0, o_alu_op = `ALU_CTL_ADD, o_alu_shift = `ALU_SHIFT_SLL, all flags 0.
- Register update priority on each rising edge:
  1. i_flush: load bubble.
  2. i_stall: hold every output unchanged.
  3. Otherwise, if i_valid = 1: load the decoded values with o_valid = 1.
  4. Otherwise (i_valid = 0): load bubble.
- i_flush and i_stall asserted together: flush wins.
- o_illegal, o_is_branch, o_br_use_zero and o_br_invert are asserted only when o_valid = 1. An illegal instruction still loads o_valid = 1 so that a downstream trap can see it.
- Reset: asynchronous assertion loads the bubble value immediately, with no clock needed. Release is synchronous to i_clk. Reset during stall or flush also yields a bubble.
- No arithmetic is performed here; operands pass through at width W unmodified, and the constant 4 is zero-extended to W.

Test Plan:
- Reset: assert i_rst mid-cycle with o_valid = 1 -> all outputs go to bubble values with no clock edge; after release and one valid ADD instruction, o_valid = 1 on the next edge.
- OP decode, rs1 = 7, rs2 = 3:
  - funct3 000, f7_5 = 1 -> o_alu_op = SUB, A = 7, B = 3.
  - funct3 101, f7_5 = 1 -> SHIFT/SRA.
  - funct3 101, f7_5 = 0 -> SHIFT/SRL.
  - funct3 011 -> LESS_UNS.
- Immediates and PC:
  - OP-IMM funct3 000, f7_5 = 1, imm = -5 -> ADD, B = all-ones-minus-4 (not SUB).
  - AUIPC, pc = 0x100, imm = 0x1000 -> A = 0x100, B = 0x1000, ADD.
  - JAL, pc = 0x40 -> A = 0x40, B = 4.
- Branches:
  - BNE -> SUB, is_branch = 1, use_zero = 1, invert = 1.
  - BGEU -> LESS_UNS, use_zero = 0, invert = 1.
  - funct3 010 -> o_illegal = 1 with o_valid = 1.
- Hold and bubble:
  - Load ADD, then hold i_stall for 3 cycles while changing the inputs -> outputs unchanged.
  - i_stall and i_flush asserted together -> bubble on the next edge.
  - i_valid = 0 -> bubble.
- Illegal opcode 0x7F -> o_illegal = 1, A = B = 0, o_alu_op = ADD. A following flush clears o_illegal to 0.
